// File: rtl/execute_stage_pkg.sv
// Shared opcode map, CCR bit layout and opcode-class helpers for the execute stage.
package exec_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SETC = 5'b00001;
    localparam logic [OPC_W-1:0] OP_CLRC = 5'b00010;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_INC  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_DEC  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_MOV  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01100;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    // Any opcode that touches the flags (SETC..SHR)
    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_SETC) && (op <= OP_SHR);
    endfunction

    function automatic logic writes_back(input logic [OPC_W-1:0] op);
        return (op >= OP_NOT) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU: result plus new flag values and a mask of which CCR bits change.
module alu_core
    import exec_pkg::*;
#(
    parameter int DATA_W = 17
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              n,
    output logic              c,
    output logic [2:0]        flag_mask
);

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] wide;

    always_comb begin
        wide      = '0;
        c         = cin;
        flag_mask = '0;
        case (op)
            OP_NOP:  wide = '0;
            OP_SETC: begin c = 1'b1; flag_mask[CCR_C] = 1'b1; end
            OP_CLRC: begin c = 1'b0; flag_mask[CCR_C] = 1'b1; end
            OP_NOT:  wide = {1'b0, ~b};
            OP_INC:  wide = {1'b0, b} + ONE;
            OP_DEC:  wide = {1'b0, b} - ONE;
            OP_MOV:  wide = {1'b0, a};
            OP_ADD:  wide = {1'b0, b} + {1'b0, a};
            OP_SUB:  wide = {1'b0, b} - {1'b0, a};
            OP_AND:  wide = {1'b0, b & a};
            OP_OR:   wide = {1'b0, b | a};
            OP_SHL:  wide = {b, 1'b0};
            OP_SHR:  wide = {2'b00, b[DATA_W-1:1]};
            default: wide = {1'b0, a};
        endcase

        // Top bit of the wide result is carry/borrow/shifted-out MSB
        case (op)
            OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_SHL: begin
                c = wide[DATA_W];
                flag_mask[CCR_C] = 1'b1;
            end
            OP_SHR: begin
                c = b[0];
                flag_mask[CCR_C] = 1'b1;
            end
            default: ;
        endcase

        if (writes_back(op)) begin
            flag_mask[CCR_Z] = 1'b1;
            flag_mask[CCR_N] = 1'b1;
        end

        result = wide[DATA_W-1:0];
        z      = (result == '0);
        n      = result[DATA_W-1];
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: EX->EX forwarding, ALU, CCR and the EX/MEM output registers.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int OP_W   = 5,
    parameter int RA_W   = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ST,
    input  logic              SST,
    input  logic [DATA_W-1:0] Reg1,
    input  logic [DATA_W-1:0] Reg2,
    input  logic [OP_W-1:0]   Instruction,
    input  logic [RA_W-1:0]   SrcAddress,
    input  logic [RA_W-1:0]   RegDestination,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] ResultOut,
    output logic [DATA_W-1:0] StoreDataOut,
    output logic [OP_W-1:0]   InstructionOut,
    output logic [RA_W-1:0]   RegDestinationOut,
    output logic              WBEnOut,
    output logic              STOut,
    output logic              SSTOut,
    output logic [2:0]        CCR
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_z;
    logic              alu_n;
    logic              alu_c;
    logic [2:0]        alu_mask;
    logic [2:0]        ccr_next;

    // A bubble leaves WBEnOut low, so a flushed instruction is never forwarded
    always_comb begin
        op_a = Reg1;
        op_b = Reg2;
        if (WBEnOut && (RegDestinationOut == SrcAddress))     op_a = ResultOut;
        if (WBEnOut && (RegDestinationOut == RegDestination)) op_b = ResultOut;
    end

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op        (Instruction),
        .a         (op_a),
        .b         (op_b),
        .cin       (CCR[CCR_C]),
        .result    (alu_res),
        .z         (alu_z),
        .n         (alu_n),
        .c         (alu_c),
        .flag_mask (alu_mask)
    );

    always_comb begin
        ccr_next = CCR;
        if (alu_mask[CCR_Z]) ccr_next[CCR_Z] = alu_z;
        if (alu_mask[CCR_N]) ccr_next[CCR_N] = alu_n;
        if (alu_mask[CCR_C]) ccr_next[CCR_C] = alu_c;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ResultOut         <= '0;
            StoreDataOut      <= '0;
            InstructionOut    <= '0;
            RegDestinationOut <= '0;
            WBEnOut           <= 1'b0;
            STOut             <= 1'b0;
            SSTOut            <= 1'b0;
            CCR               <= '0;
        end else if (Flush) begin
            ResultOut         <= '0;
            StoreDataOut      <= '0;
            InstructionOut    <= '0;
            RegDestinationOut <= '0;
            WBEnOut           <= 1'b0;
            STOut             <= 1'b0;
            SSTOut            <= 1'b0;
        end else if (!Stall) begin
            ResultOut         <= alu_res;
            StoreDataOut      <= op_b;
            InstructionOut    <= Instruction;
            RegDestinationOut <= RegDestination;
            WBEnOut           <= writes_back(Instruction);
            STOut             <= ST;
            SSTOut            <= SST;
            CCR               <= ccr_next;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ST, SST, Stall, Flush;
    logic [16:0] Reg1, Reg2;
    logic [4:0]  Instruction;
    logic [2:0]  SrcAddress, RegDestination;
    logic [16:0] ResultOut, StoreDataOut;
    logic [4:0]  InstructionOut;
    logic [2:0]  RegDestinationOut;
    logic        WBEnOut, STOut, SSTOut;
    logic [2:0]  CCR;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {ResultOut, StoreDataOut, InstructionOut, RegDestinationOut, WBEnOut, STOut, SSTOut, CCR}
    logic [47:0] obs;
    logic [47:0] exp;
    assign obs = {ResultOut, StoreDataOut, InstructionOut, RegDestinationOut,
                  WBEnOut, STOut, SSTOut, CCR};

    execute_stage #(.DATA_W(17), .OP_W(5), .RA_W(3)) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .ST                (ST),
        .SST               (SST),
        .Reg1              (Reg1),
        .Reg2              (Reg2),
        .Instruction       (Instruction),
        .SrcAddress        (SrcAddress),
        .RegDestination    (RegDestination),
        .Stall             (Stall),
        .Flush             (Flush),
        .ResultOut         (ResultOut),
        .StoreDataOut      (StoreDataOut),
        .InstructionOut    (InstructionOut),
        .RegDestinationOut (RegDestinationOut),
        .WBEnOut           (WBEnOut),
        .STOut             (STOut),
        .SSTOut            (SSTOut),
        .CCR               (CCR)
    );

    always #5 Clk = ~Clk;

    // Drive one instruction at negedge, sample 1 time unit after the posedge
    task automatic apply(input logic [4:0] op, input logic [16:0] r1, input logic [16:0] r2,
                         input logic [2:0] src, input logic [2:0] dst);
        @(negedge Clk);
        Instruction    = op;
        Reg1           = r1;
        Reg2           = r2;
        SrcAddress     = src;
        RegDestination = dst;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        exp = '0;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_init got=%h exp=%h", obs, exp); else pass_cnt++;
        @(negedge Clk);
        Rst = 1'b0;
        apply(5'h07, 17'h00001, 17'h00002, 3'd1, 3'd2);
        exp = {17'h00003, 17'h00002, 5'h07, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_pre_add got=%h exp=%h", obs, exp); else pass_cnt++;
        #3 Rst = 1'b1;
        #1;
        exp = '0;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_async got=%h exp=%h", obs, exp); else pass_cnt++;
        @(posedge Clk);
        #1;
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_held got=%h exp=%h", obs, exp); else pass_cnt++;
        Rst = 1'b0;
    endtask

    task automatic test_add_sub_flags;
        apply(5'h07, 17'h00001, 17'h1FFFF, 3'd1, 3'd2);
        exp = {17'h00000, 17'h1FFFF, 5'h07, 3'd2, 1'b1, 1'b0, 1'b0, 3'b101};
        total_cnt++;
        if (obs !== exp) $display("FAIL add_wrap got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h08, 17'h00005, 17'h00003, 3'd3, 3'd4);
        exp = {17'h1FFFE, 17'h00003, 5'h08, 3'd4, 1'b1, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL sub_borrow got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h01, 17'h0, 17'h0, 3'd0, 3'd0);
        total_cnt++;
        if ({WBEnOut, CCR} !== 4'b0110) $display("FAIL setc got=%b exp=0110", {WBEnOut, CCR}); else pass_cnt++;
        apply(5'h02, 17'h0, 17'h0, 3'd0, 3'd0);
        total_cnt++;
        if ({WBEnOut, CCR} !== 4'b0010) $display("FAIL clrc got=%b exp=0010", {WBEnOut, CCR}); else pass_cnt++;
        apply(5'h01, 17'h0, 17'h0, 3'd0, 3'd0);
        total_cnt++;
        if ({WBEnOut, CCR} !== 4'b0110) $display("FAIL setc2 got=%b exp=0110", {WBEnOut, CCR}); else pass_cnt++;
    endtask

    task automatic test_unary_logic;
        apply(5'h00, 17'h0, 17'h00000, 3'd0, 3'd0);
        exp = {17'h00000, 17'h00000, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL nop got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h04, 17'h0, 17'h1FFFF, 3'd0, 3'd3);
        exp = {17'h00000, 17'h1FFFF, 5'h04, 3'd3, 1'b1, 1'b0, 1'b0, 3'b101};
        total_cnt++;
        if (obs !== exp) $display("FAIL inc_wrap got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h05, 17'h0, 17'h00000, 3'd0, 3'd4);
        exp = {17'h1FFFF, 17'h00000, 5'h05, 3'd4, 1'b1, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL dec_wrap got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h0B, 17'h0, 17'h10001, 3'd0, 3'd5);
        exp = {17'h00002, 17'h10001, 5'h0B, 3'd5, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL shl got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h0C, 17'h0, 17'h00003, 3'd0, 3'd6);
        exp = {17'h00001, 17'h00003, 5'h0C, 3'd6, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL shr got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h03, 17'h0, 17'h00000, 3'd0, 3'd7);
        exp = {17'h1FFFF, 17'h00000, 5'h03, 3'd7, 1'b1, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL not got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h09, 17'h000F0, 17'h000FF, 3'd1, 3'd2);
        exp = {17'h000F0, 17'h000FF, 5'h09, 3'd2, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL and got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h0A, 17'h000F0, 17'h0000F, 3'd1, 3'd3);
        exp = {17'h000FF, 17'h0000F, 5'h0A, 3'd3, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL or got=%h exp=%h", obs, exp); else pass_cnt++;
    endtask

    task automatic test_forward;
        apply(5'h00, 17'h0, 17'h0, 3'd0, 3'd0);
        apply(5'h06, 17'h00007, 17'h00000, 3'd5, 3'd1);
        exp = {17'h00007, 17'h00000, 5'h06, 3'd1, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL mov got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h07, 17'h00000, 17'h00002, 3'd1, 3'd2);
        exp = {17'h00009, 17'h00002, 5'h07, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL fwd_a got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h04, 17'h00000, 17'h00000, 3'd0, 3'd2);
        exp = {17'h0000A, 17'h00009, 5'h04, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL fwd_b got=%h exp=%h", obs, exp); else pass_cnt++;
        apply(5'h07, 17'h00000, 17'h00000, 3'd2, 3'd2);
        exp = {17'h00014, 17'h0000A, 5'h07, 3'd2, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL fwd_both got=%h exp=%h", obs, exp); else pass_cnt++;
        ST = 1'b1;
        apply(5'h10, 17'h00123, 17'h00055, 3'd3, 3'd3);
        exp = {17'h00123, 17'h00055, 5'h10, 3'd3, 1'b0, 1'b1, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL nonalu_st got=%h exp=%h", obs, exp); else pass_cnt++;
        ST = 1'b0;
        SST = 1'b1;
        apply(5'h11, 17'h000AA, 17'h00000, 3'd3, 3'd3);
        exp = {17'h000AA, 17'h00000, 5'h11, 3'd3, 1'b0, 1'b0, 1'b1, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL nonalu_nofwd got=%h exp=%h", obs, exp); else pass_cnt++;
        SST = 1'b0;
        apply(5'h00, 17'h00011, 17'h00077, 3'd0, 3'd0);
        exp = {17'h00000, 17'h00077, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL nop_store got=%h exp=%h", obs, exp); else pass_cnt++;
    endtask

    task automatic test_stall;
        apply(5'h07, 17'h00002, 17'h1FFFF, 3'd1, 3'd2);
        exp = {17'h00001, 17'h1FFFF, 5'h07, 3'd2, 1'b1, 1'b0, 1'b0, 3'b100};
        total_cnt++;
        if (obs !== exp) $display("FAIL stall_pre got=%h exp=%h", obs, exp); else pass_cnt++;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(5'h08, 17'(i + 10), 17'(i + 20), 3'd2, 3'd2);
            total_cnt++;
            if (obs !== exp) $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp); else pass_cnt++;
        end
        Stall = 1'b0;
        apply(5'h04, 17'h00000, 17'h00020, 3'd0, 3'd5);
        exp = {17'h00021, 17'h00020, 5'h04, 3'd5, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL stall_release got=%h exp=%h", obs, exp); else pass_cnt++;
    endtask

    task automatic test_flush;
        apply(5'h08, 17'h00005, 17'h00003, 3'd1, 3'd2);
        exp = {17'h1FFFE, 17'h00003, 5'h08, 3'd2, 1'b1, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL flush_pre got=%h exp=%h", obs, exp); else pass_cnt++;
        Flush = 1'b1;
        ST = 1'b1;
        SST = 1'b1;
        apply(5'h07, 17'h00001, 17'h00001, 3'd1, 3'd3);
        exp = {17'h00000, 17'h00000, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'b110};
        total_cnt++;
        if (obs !== exp) $display("FAIL flush_bubble got=%h exp=%h", obs, exp); else pass_cnt++;
        Flush = 1'b0;
        ST = 1'b0;
        SST = 1'b0;
        apply(5'h07, 17'h0000A, 17'h00014, 3'd0, 3'd0);
        exp = {17'h0001E, 17'h00014, 5'h07, 3'd0, 1'b1, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL flush_nofwd got=%h exp=%h", obs, exp); else pass_cnt++;
        Flush = 1'b1;
        Stall = 1'b1;
        apply(5'h08, 17'h00001, 17'h00000, 3'd1, 3'd1);
        exp = {17'h00000, 17'h00000, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000};
        total_cnt++;
        if (obs !== exp) $display("FAIL flush_over_stall got=%h exp=%h", obs, exp); else pass_cnt++;
        Flush = 1'b0;
        Stall = 1'b0;
    endtask

    initial begin
        Rst            = 1'b1;
        ST             = 1'b0;
        SST            = 1'b0;
        Stall          = 1'b0;
        Flush          = 1'b0;
        Reg1           = '0;
        Reg2           = '0;
        Instruction    = '0;
        SrcAddress     = '0;
        RegDestination = '0;
        test_reset();
        test_add_sub_flags();
        test_unary_logic();
        test_forward();
        test_stall();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the processor pipeline, directly downstream of the decode/execute buffer. Consumes decoded operands, opcode and register addresses. Computes the ALU result and maintains the condition-code register (CCR: Z, N, C). Registers everything the memory stage needs into its own output registers, and provides single-level EX→EX operand forwarding, stall hold and flush-to-bubble.

## Interface
Parameters:
- DATA_W, 17, operand/result width
- OP_W, 5, opcode width
- RA_W, 3, register-address width

Ports:
- Clk  in  1  pipeline clock, all state updates on posedge
- Rst  in  1  asynchronous, active-high reset
- ST, SST  in  1 each  memory control bits from decode buffer, passed through
- Reg1  in  DATA_W  source operand value (Rsrc)
- Reg2  in  DATA_W  destination operand value (Rdst)
- Instruction  in  OP_W  opcode
- SrcAddress  in  RA_W  Rsrc index
- RegDestination  in  RA_W  Rdst index
- Stall  in  1  memory stage busy; hold all state
- Flush  in  1  kill instruction currently entering
- ResultOut  out  DATA_W  registered ALU result
- StoreDataOut  out  DATA_W  registered (forwarded) Reg2 value
- InstructionOut  out  OP_W  registered opcode
- RegDestinationOut  out  RA_W  registered Rdst index
- WBEnOut  out  1  result must be written to RegDestinationOut
- STOut, SSTOut  out  1 each  registered pass-through controls
- CCR  out  3  {C, N, Z}, registered

## Operation
- Opcodes:
  - NOP 00000
  - SETC 00001
  - CLRC 00010
  - NOT 00011
  - INC 00100
  - DEC 00101
  - MOV 00110
  - ADD 00111
  - SUB 01000
  - AND 01001
  - OR 01010
  - SHL 01011
  - SHR 01100
  - Any other code is a non-ALU op.
- Operand select (forwarding):
  - A = Reg1, B = Reg2, except where overridden below.
  - If WBEnOut=1 and RegDestinationOut==SrcAddress, then A=ResultOut.
  - If WBEnOut=1 and RegDestinationOut==RegDestination, then B=ResultOut.
- Results, all DATA_W bits, computed with a DATA_W+1 intermediate:
  - NOT: ~B
  - INC: B+1
  - DEC: B-1
  - MOV: A
  - ADD: B+A
  - SUB: B-A
  - AND: B&A
  - OR: B|A
  - SHL: B<<1
  - SHR: B>>1 (logical)
- WBEnOut=1 for NOT through SHR, else 0.
- Non-ALU ops:
  - ResultOut=A (address path), flags unchanged, WBEnOut=0.
  - ST/SST pass through unchanged.
- Flags, updated only by ALU ops:
  - Z = (result==0), for NOT through SHR.
  - N = result[DATA_W-1], for NOT through SHR.
  - C = carry-out for INC and ADD.
  - C = borrow for DEC and SUB (1 when B<A).
  - C = shifted-out bit for SHL/SHR.
  - C unchanged for NOT, MOV, AND, OR.
  - SETC sets C=1; CLRC sets C=0; Z and N unchanged for both.
- NOP: WBEnOut=0, CCR unchanged, ResultOut=0.
- StoreDataOut=B (forwarded).

## Timing
- Latency is 1 cycle: inputs sampled at posedge N appear on outputs after posedge N.
- Inputs are stable from the preceding negedge.
- Stall=1: all output registers and CCR hold; no forwarding state changes.
- Flush=1 (has priority over Stall):
  - Outputs load a bubble: Instruction=NOP, WBEnOut=0, ST=SST=0, ResultOut=0, StoreDataOut=0, RegDestinationOut=0.
  - CCR is unchanged.
- Reset (asynchronous, any time including mid-stall): every output and CCR go to 0 immediately, and stay at 0 until the first posedge after Rst deasserts.
- Forwarding occurs only when the previous instruction reached the output registers, i.e. it was not flushed, so WBEnOut=1.
- Forwarding priority: both A and B may forward in the same cycle.
- Wrap-around: INC of all-ones gives 0 with C=1; DEC of 0 gives all-ones with C=1.

## Structure
- Package exec_pkg holds:
  - opcode localparams
  - CCR bit indices (Z=0, N=1, C=2)
  - the is_alu_op / writes_back helper functions
- Sub-module alu_core: purely combinational; (op, A, B, Cin) → (result, Z, N, C, flag-update mask).
- execute_stage owns forwarding muxes, output registers and CCR.

## Test plan
- Reset mid-ADD, Rst pulsed between edges → all outputs and CCR read 0 before the next posedge.
- ADD with A=0x00001, B=0x1FFFF → ResultOut=0x00000, CCR={C=1,N=0,Z=1}, WBEnOut=1.
- SUB with A=5, B=3 → ResultOut=0x1FFFE, C=1, N=1, Z=0. Then SETC → C=1 with Z,N held; then CLRC → C=0.
- Back-to-back MOV R1←7 then ADD R2=R2+R1, with Reg1=0 (stale) and Reg2=2 → second ResultOut=9 via forwarding.
- Stall held 3 cycles during ADD: outputs and CCR frozen, inputs changing; release → next instruction executes once.
- Flush with ST=1 and opcode ADD → InstructionOut=NOP, STOut=0, WBEnOut=0, CCR unchanged; the following instruction does not forward from it.
